// File: rtl/blackjack_pkg.sv
// Shared blackjack types: deck geometry, destination-hand encoding and dealer FSM states.
package blackjack_pkg;

    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned NUM_RANKS = 13;

    typedef enum logic [1:0] {
        P1     = 2'b00,
        P2     = 2'b01,
        DEALER = 2'b10
    } dest_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REFILL = 2'b01,
        PROBE  = 2'b10,
        DEAL   = 2'b11
    } dealer_state_t;

    // The unused code 11 folds onto the dealer hand.
    function automatic dest_t to_dest(input logic [1:0] raw);
        dest_t d;
        case (raw)
            2'b00:   d = P1;
            2'b01:   d = P2;
            default: d = DEALER;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); a zero seed is replaced by 1.
module lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] seed_s;
    logic        fb_s;

    assign seed_s = (seed == 16'h0000) ? 16'h0001 : seed;
    assign fb_s   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign q      = lfsr_q;

    // Next-state shift with feedback into bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], fb_s};
    end

    // Shift register, advancing every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= seed_s;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/deck_dealer.sv
// 52-card dealer: dealt-card mask, linear probing from an LFSR start index, req/ack handshake.
module deck_dealer
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] req_dest,
    input  logic       shuffle,
    output logic       ack,
    output logic [3:0] card,
    output logic [1:0] card_dest,
    output logic       busy,
    output logic [5:0] cards_left,
    output logic       deck_empty
);

    localparam logic [5:0] FULL_DECK = 6'(DECK_SIZE);
    localparam logic [5:0] LAST_IDX  = 6'(DECK_SIZE - 1);

    dealer_state_t          state_q, state_d;
    logic [DECK_SIZE-1:0]   mask_q, mask_d;
    logic [5:0]             idx_q, idx_d;
    dest_t                  dest_q, dest_d;
    logic [3:0]             card_q, card_d;
    logic [1:0]             card_dest_q, card_dest_d;
    logic [5:0]             left_q, left_d;
    logic                   empty_q, empty_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   pend_q, pend_d;

    logic [15:0]            lfsr_s;
    logic [5:0]             start_idx_s;
    logic                   shuf_s;
    logic [5:0]             avail_s;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_s)
    );

    // Rank of a deck index: suits occupy 13-entry blocks, so subtract the block base.
    function automatic logic [3:0] rank_of(input logic [5:0] i);
        logic [5:0] r;
        if (i >= 6'd39) begin
            r = i - 6'd39;
        end else if (i >= 6'd26) begin
            r = i - 6'd26;
        end else if (i >= 6'd13) begin
            r = i - 6'd13;
        end else begin
            r = i;
        end
        return r[3:0] + 4'd1;
    endfunction

    assign start_idx_s = (lfsr_s[5:0] >= FULL_DECK) ? (lfsr_s[5:0] - FULL_DECK) : lfsr_s[5:0];
    assign shuf_s      = shuffle | pend_q;

    // Dealer FSM next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        dest_d      = dest_q;
        card_d      = card_q;
        card_dest_d = card_dest_q;
        left_d      = left_q;
        pend_d      = pend_q | shuffle;
        avail_s     = left_q;
        case (state_q)
            IDLE: begin
                // Any deferred shuffle is consumed here, ahead of a same-cycle request.
                pend_d = 1'b0;
                if (shuf_s) begin
                    mask_d  = '0;
                    left_d  = FULL_DECK;
                    avail_s = FULL_DECK;
                end else begin
                    avail_s = left_q;
                end
                if (req) begin
                    dest_d = to_dest(req_dest);
                    if (avail_s != 6'd0) begin
                        idx_d   = start_idx_s;
                        state_d = PROBE;
                    end else begin
                        state_d = REFILL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REFILL: begin
                mask_d  = '0;
                left_d  = FULL_DECK;
                idx_d   = start_idx_s;
                state_d = PROBE;
            end
            PROBE: begin
                if (mask_q[idx_q]) begin
                    idx_d   = (idx_q == LAST_IDX) ? 6'd0 : (idx_q + 6'd1);
                    state_d = PROBE;
                end else begin
                    mask_d[idx_q] = 1'b1;
                    left_d        = left_q - 6'd1;
                    card_d        = rank_of(idx_q);
                    card_dest_d   = dest_q;
                    state_d       = DEAL;
                end
            end
            DEAL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ack_d   = (state_d == DEAL);
        busy_d  = (state_d != IDLE);
        empty_d = (left_d == 6'd0);
    end

    // State, deck and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            idx_q       <= 6'd0;
            dest_q      <= P1;
            card_q      <= 4'd0;
            card_dest_q <= 2'b00;
            left_q      <= FULL_DECK;
            empty_q     <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            dest_q      <= dest_d;
            card_q      <= card_d;
            card_dest_q <= card_dest_d;
            left_q      <= left_d;
            empty_q     <= empty_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
        end
    end

    assign ack        = ack_q;
    assign card       = card_q;
    assign card_dest  = card_dest_q;
    assign busy       = busy_q;
    assign cards_left = left_q;
    assign deck_empty = empty_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Directed bench for deck_dealer: full-deck draws, refill, ignored requests, shuffles, reset abort.
module tb_deck_dealer;
    import blackjack_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [1:0] req_dest = 2'b00;
    logic       shuffle = 1'b0;
    logic       ack;
    logic [3:0] card;
    logic [1:0] card_dest;
    logic       busy;
    logic [5:0] cards_left;
    logic       deck_empty;

    int checks = 0;
    int failures = 0;

    deck_dealer #(.LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_dest   (req_dest),
        .shuffle    (shuffle),
        .ack        (ack),
        .card       (card),
        .card_dest  (card_dest),
        .busy       (busy),
        .cards_left (cards_left),
        .deck_empty (deck_empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 1'b0;
        shuffle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One draw from IDLE; returns at #1 after the edge that follows the ack cycle.
    task automatic draw(input logic [1:0] dest, input logic shuf_idle, input logic shuf_busy,
                        output logic [3:0] c, output logic [1:0] cd, output logic [5:0] left,
                        output logic [5:0] ix, output int lat, output dealer_state_t st1);
        req = 1'b1;
        req_dest = dest;
        shuffle = shuf_idle;
        @(posedge clk);
        #1;
        req = 1'b0;
        shuffle = shuf_busy;
        lat = 1;
        st1 = dut.state_q;
        while (ack !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            shuffle = 1'b0;
            lat++;
        end
        check_eq("ack_seen", int'(ack), 1);
        check_eq("busy_in_ack", int'(busy), 1);
        c = card;
        cd = card_dest;
        left = cards_left;
        ix = dut.idx_q;
        @(posedge clk);
        #1;
        check_eq("busy_after_ack", int'(busy), 0);
        check_eq("ack_one_cycle", int'(ack), 0);
    endtask

    logic [3:0]    c;
    logic [1:0]    cd;
    logic [5:0]    left;
    logic [5:0]    ix;
    int            lat;
    dealer_state_t st1;
    logic [1:0]    d;
    int            exp_dest;
    logic [51:0]   shadow;
    int            rank_cnt [14];
    logic [3:0]    seq_a [8];
    int            acks;

    initial begin
        shadow = '0;
        for (int i = 0; i < 14; i++) rank_cnt[i] = 0;

        do_reset();
        check_eq("rst_ack", int'(ack), 0);
        check_eq("rst_card", int'(card), 0);
        check_eq("rst_card_dest", int'(card_dest), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_cards_left", int'(cards_left), 52);
        check_eq("rst_deck_empty", int'(deck_empty), 0);

        // 52 back-to-back draws; destinations cycle 10,11,00,01.
        for (int n = 0; n < 52; n++) begin
            d = 2'((n + 2) % 4);
            exp_dest = (d == 2'b11) ? 2 : int'(d);
            draw(d, 1'b0, 1'b0, c, cd, left, ix, lat, st1);
            check_eq("draw_first_state", int'(st1), int'(PROBE));
            check_eq("draw_latency_ok", int'(lat >= 2 && lat <= 53), 1);
            check_eq("draw_card_dest", int'(cd), exp_dest);
            check_eq("draw_card_range", int'(c >= 4'd1 && c <= 4'd13), 1);
            check_eq("draw_rank_of_idx", int'(c), (int'(ix) % 13) + 1);
            check_eq("draw_idx_unique", int'(shadow[ix]), 0);
            check_eq("draw_cards_left", int'(left), 51 - n);
            shadow[ix] = 1'b1;
            rank_cnt[c]++;
            if (n < 8) seq_a[n] = c;
        end
        for (int r = 1; r <= 13; r++) check_eq($sformatf("rank_count_%0d", r), rank_cnt[r], 4);
        check_eq("full_deal_left", int'(cards_left), 0);
        check_eq("full_deal_empty", int'(deck_empty), 1);

        // Empty deck: refill path adds one cycle.
        draw(2'b01, 1'b0, 1'b0, c, cd, left, ix, lat, st1);
        check_eq("refill_state", int'(st1), int'(REFILL));
        check_eq("refill_latency_ok", int'(lat >= 3 && lat <= 54), 1);
        check_eq("refill_left", int'(left), 51);
        check_eq("refill_empty", int'(deck_empty), 0);
        check_eq("refill_dest", int'(cd), 1);

        // Requests toggling throughout a draw yield exactly one ack.
        acks = 0;
        req = 1'b1;
        req_dest = 2'b00;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                acks++;
                req = 1'b0;
            end else if (acks == 0) begin
                req = ~req;
            end else begin
                req = 1'b0;
            end
        end
        check_eq("pulse_req_acks", acks, 1);
        check_eq("pulse_req_left", int'(cards_left), 50);

        // Plain shuffle in IDLE.
        shuffle = 1'b1;
        @(posedge clk);
        #1;
        shuffle = 1'b0;
        check_eq("idle_shuffle_left", int'(cards_left), 52);
        check_eq("idle_shuffle_mask", $countones(dut.mask_q), 0);

        for (int n = 0; n < 10; n++) draw(2'b10, 1'b0, 1'b0, c, cd, left, ix, lat, st1);
        check_eq("ten_deals_left", int'(cards_left), 42);

        // Shuffle while busy: in-flight card completes, shuffle lands after returning to IDLE.
        draw(2'b00, 1'b0, 1'b1, c, cd, left, ix, lat, st1);
        check_eq("busy_shuffle_ack_left", int'(left), 41);
        check_eq("busy_shuffle_idle_left", int'(cards_left), 41);
        @(posedge clk);
        #1;
        check_eq("busy_shuffle_applied", int'(cards_left), 52);
        check_eq("busy_shuffle_mask", $countones(dut.mask_q), 0);

        // Shuffle together with a request draws from the full deck.
        for (int n = 0; n < 3; n++) draw(2'b01, 1'b0, 1'b0, c, cd, left, ix, lat, st1);
        check_eq("pre_shufreq_left", int'(cards_left), 49);
        draw(2'b10, 1'b1, 1'b0, c, cd, left, ix, lat, st1);
        check_eq("shufreq_state", int'(st1), int'(PROBE));
        check_eq("shufreq_left", int'(left), 51);
        check_eq("shufreq_mask", $countones(dut.mask_q), 1);

        // Reset during PROBE aborts the draw.
        req = 1'b1;
        req_dest = 2'b10;
        @(posedge clk);
        #1;
        req = 1'b0;
        check_eq("abort_in_probe", int'(dut.state_q), int'(PROBE));
        reset = 1'b1;
        acks = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) acks++;
        end
        check_eq("abort_no_ack", acks, 0);
        check_eq("abort_left", int'(cards_left), 52);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_mask", $countones(dut.mask_q), 0);

        // Same seed and timing reproduce the first eight cards.
        do_reset();
        for (int n = 0; n < 8; n++) begin
            d = 2'((n + 2) % 4);
            draw(d, 1'b0, 1'b0, c, cd, left, ix, lat, st1);
            check_eq($sformatf("repeat_card_%0d", n), int'(c), int'(seq_a[n]));
        end
        check_eq("repeat_left", int'(cards_left), 44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
